// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states,
// and helpers that map an access size and byte offset onto the four byte lanes.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  // Undefined encodings fall through to a full-word access.
  function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: byte_enable = 4'b0001 << addr_lo;
      F3_H, F3_HU: byte_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:     byte_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      F3_B, F3_BU: store_lanes = {4{wdata[7:0]}};
      F3_H, F3_HU: store_lanes = {2{wdata[15:0]}};
      default:     store_lanes = wdata;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = addr_lo[0];
      default:     misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Combinational load formatter: picks the addressed byte/half out of a word and
// sign- or zero-extends it to 32 bits.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'b0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'b0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with fixed wait latency, byte-lane stores and formatted loads.
// Optional misaligned-access detection is enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall
`ifdef DMEM_MISALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_t state, state_next;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [AW-1:0] lat_idx;
  logic [1:0]    lat_lo;
  logic [31:0]   lat_wdata;
  logic [2:0]    lat_f3;
  logic [31:0]   mem [DEPTH];
  logic          access;
  logic          bad;
  logic [3:0]    be;
  logic [31:0]   lanes;
  logic [31:0]   load_val;
  logic          unused_addr;

  // Upper address bits are discarded so indices alias modulo DEPTH.
  assign unused_addr = ^addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == IDLE && req) begin
      cnt <= CW'(LATENCY - 1);
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Request fields are captured once so the pipeline may change its inputs while waiting.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      lat_we    <= we;
      lat_idx   <= addr[AW+1:2];
      lat_lo    <= addr[1:0];
      lat_wdata <= wdata;
      lat_f3    <= funct3;
    end
  end

  assign access = (state == WAIT) && (cnt == '0);
  assign be     = byte_enable(lat_f3, lat_lo);
  assign lanes  = store_lanes(lat_f3, lat_wdata);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign bad = misaligned(lat_f3, lat_lo);

  always_ff @(posedge clk) begin
    if (reset) misalign <= 1'b0;
    else       misalign <= access && bad;
  end
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset && access && lat_we && !bad) begin
      if (be[0]) mem[lat_idx][7:0]   <= lanes[7:0];
      if (be[1]) mem[lat_idx][15:8]  <= lanes[15:8];
      if (be[2]) mem[lat_idx][23:16] <= lanes[23:16];
      if (be[3]) mem[lat_idx][31:24] <= lanes[31:24];
    end
  end

  dmem_load_ext u_load_ext (
    .word    (mem[lat_idx]),
    .addr_lo (lat_lo),
    .funct3  (lat_f3),
    .result  (load_val)
  );

  // rdata only moves on loads (or is cleared by a rejected misaligned access).
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (access && bad) begin
      rdata <= '0;
    end else if (access && !lat_we) begin
      rdata <= load_val;
    end
  end

  assign ready = (state == RESP);
  assign stall = req & ~ready;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=2, DEPTH=1024);
// covers the misalign port too when DMEM_MISALIGN_CHECK_EN is defined.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        mis_seen;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .funct3   (funct3),
    .rdata    (rdata),
    .ready    (ready),
    .stall    (stall)
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    .misalign (misalign)
`endif
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one access and waits for ready; inputs are scrambled during the wait.
  task automatic apply_stimulus(input logic st, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f3, input bit hold, output logic [31:0] rd);
    int n;
    n = 0;
    req = 1'b1; we = st; addr = a; wdata = d; funct3 = f3;
    do begin
      step();
      n++;
      if (n == 1) begin
        we = ~st; addr = ~a; wdata = ~d; funct3 = F3_B;
      end
      if (!ready) check_output("stall_wait", {31'b0, stall}, 32'd1);
    end while (!ready && n < 20);
    check_output("latency", n, LATENCY + 1);
    check_output("stall_at_ready", {31'b0, stall}, 32'd0);
    rd = rdata;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis_seen = misalign;
`else
    mis_seen = 1'b0;
`endif
    we = st; addr = a; wdata = d; funct3 = f3;
    if (!hold) req = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int n;

    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; funct3 = F3_W;
    step();
    check_output("reset_ready", {31'b0, ready}, 32'd0);
    check_output("reset_stall", {31'b0, stall}, 32'd0);
    check_output("reset_rdata", rdata, 32'd0);
    step();
    reset = 1'b0;
    step();

    apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, F3_W, 1'b0, rd);
    step();
    apply_stimulus(1'b0, 32'h10, 32'h0, F3_W, 1'b0, rd);
    check_output("lw_10", rd, 32'hDEADBEEF);
    step();
    apply_stimulus(1'b1, 32'h10, 32'h11223344, F3_W, 1'b0, rd);
    check_output("rdata_hold_store", rd, 32'hDEADBEEF);
    step();
    apply_stimulus(1'b1, 32'h13, 32'h000000AA, F3_B, 1'b0, rd);
    step();
    apply_stimulus(1'b0, 32'h10, 32'h0, F3_W, 1'b0, rd);
    check_output("lw_after_sb", rd, 32'hAA223344);
    step();
    apply_stimulus(1'b0, 32'h13, 32'h0, F3_B, 1'b0, rd);
    check_output("lb_13", rd, 32'hFFFFFFAA);
    step();
    apply_stimulus(1'b0, 32'h13, 32'h0, F3_BU, 1'b0, rd);
    check_output("lbu_13", rd, 32'h000000AA);
    step();

    apply_stimulus(1'b1, 32'h12, 32'h00008001, F3_H, 1'b0, rd);
    step();
    apply_stimulus(1'b0, 32'h12, 32'h0, F3_H, 1'b0, rd);
    check_output("lh_12", rd, 32'hFFFF8001);
    step();
    apply_stimulus(1'b0, 32'h12, 32'h0, F3_HU, 1'b0, rd);
    check_output("lhu_12", rd, 32'h00008001);
    step();
    apply_stimulus(1'b0, 32'h10, 32'h0, 3'b111, 1'b0, rd);
    check_output("lw_undef_f3", rd, 32'h80013344);
    step();

    apply_stimulus(1'b1, 32'h20, 32'hCAFEF00D, F3_W, 1'b0, rd);
    step();
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55; funct3 = F3_W;
    step();
    check_output("stall_before_reset", {31'b0, stall}, 32'd1);
    reset = 1'b1; req = 1'b0;
    step();
    reset = 1'b0;
    check_output("ready_after_reset", {31'b0, ready}, 32'd0);
    check_output("rdata_after_reset", rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("no_ready_idle", {31'b0, ready}, 32'd0);
    end
    apply_stimulus(1'b0, 32'h20, 32'h0, F3_W, 1'b0, rd);
    check_output("lw_20_uncommitted", rd, 32'hCAFEF00D);
    step();

    apply_stimulus(1'b1, 32'h4 * DEPTH, 32'h1234, F3_W, 1'b0, rd);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, F3_W, 1'b1, rd);
    check_output("lw_wrap", rd, 32'h1234);
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) check_output("stall_b2b_idle", {31'b0, stall}, 32'd1);
    end while (!ready && n < 20);
    check_output("b2b_gap", n, LATENCY + 2);
    check_output("b2b_rdata", rdata, 32'h1234);
    req = 1'b0;
    step();

`ifdef DMEM_MISALIGN_CHECK_EN
    apply_stimulus(1'b1, 32'h10, 32'h1, F3_W, 1'b0, rd);
    check_output("misalign_aligned", {31'b0, mis_seen}, 32'd0);
    step();
    apply_stimulus(1'b1, 32'h21, 32'hFFFF, F3_W, 1'b0, rd);
    check_output("misalign_sw21", {31'b0, mis_seen}, 32'd1);
    step();
    check_output("misalign_cleared", {31'b0, misalign}, 32'd0);
    apply_stimulus(1'b0, 32'h20, 32'h0, F3_W, 1'b0, rd);
    check_output("lw_20_after_misalign", rd, 32'hCAFEF00D);
    step();
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
